// File: rtl/pipe_hazard_sequencer.sv
// Control sequencing for the five-stage pipeline: carries decoded control through
// E/M/W and derives load-use stall, control-transfer flush and operand forwarding.
module pipe_hazard_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reg_write_d,
  input  logic [1:0] result_src_d,
  input  logic       mem_write_d,
  input  logic       jump_d,
  input  logic       beq_d,
  input  logic       bne_d,
  input  logic       jalr_d,
  input  logic [2:0] alu_control_d,
  input  logic       alu_src_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_d,
  input  logic       zero_e,
  output logic [2:0] alu_control_e,
  output logic       alu_src_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic [1:0] pc_src_e,
  output logic       mem_write_m,
  output logic       reg_write_w,
  output logic [1:0] result_src_w,
  output logic [4:0] rd_w,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       aluSrc;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       jalr;
    logic [2:0] aluControl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } exCtl_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic [4:0] rd;
  } memCtl_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [4:0] rd;
  } wbCtl_t;

  exCtl_t  exD, exQ;
  memCtl_t memQ;
  wbCtl_t  wbQ;
  logic    lwStall, taken;

  assign exD = {reg_write_d, result_src_d, mem_write_d, alu_src_d, jump_d, beq_d, bne_d,
                jalr_d, alu_control_d, rs1_d, rs2_d, rd_d};

  // A load still in E cannot yet supply its data to the instruction in D.
  assign lwStall = (exQ.resultSrc == 2'b01) && (exQ.rd != 5'd0) &&
                   ((exQ.rd == rs1_d) || (exQ.rd == rs2_d));
  assign taken   = exQ.jump || exQ.jalr || (exQ.beq && zero_e) || (exQ.bne && !zero_e);

  assign stall_f  = lwStall;
  assign stall_d  = lwStall;
  assign flush_d  = taken;
  assign flush_e  = taken || lwStall;
  assign pc_src_e = exQ.jalr ? 2'b10 : (taken ? 2'b01 : 2'b00);

  // Memory-stage producer is younger, so it wins over Writeback.
  function automatic logic [1:0] fwdSel(input logic [4:0] rs, input memCtl_t m, input wbCtl_t w);
    if (m.regWrite && (m.rd != 5'd0) && (m.rd == rs))      return 2'b10;
    else if (w.regWrite && (w.rd != 5'd0) && (w.rd == rs)) return 2'b01;
    else                                                    return 2'b00;
  endfunction

  assign forward_a_e = fwdSel(exQ.rs1, memQ, wbQ);
  assign forward_b_e = fwdSel(exQ.rs2, memQ, wbQ);

  assign alu_control_e = exQ.aluControl;
  assign alu_src_e     = exQ.aluSrc;
  assign mem_write_m   = memQ.memWrite;
  assign reg_write_w   = wbQ.regWrite;
  assign result_src_w  = wbQ.resultSrc;
  assign rd_w          = wbQ.rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      exQ  <= flush_e ? exCtl_t'('0) : exD;
      memQ <= {exQ.regWrite, exQ.resultSrc, exQ.memWrite, exQ.rd};
      wbQ  <= {memQ.regWrite, memQ.resultSrc, memQ.rd};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed, table-driven bench for pipe_hazard_sequencer plus a hand-written
// asynchronous-reset sequence.
module tb_pipe_hazard_sequencer;

  logic       clk, rst_n;
  logic       reg_write_d, mem_write_d, jump_d, beq_d, bne_d, jalr_d, alu_src_d, zero_e;
  logic [1:0] result_src_d;
  logic [2:0] alu_control_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic [2:0] alu_control_e;
  logic       alu_src_e, mem_write_m, reg_write_w, stall_f, stall_d, flush_d, flush_e;
  logic [1:0] forward_a_e, forward_b_e, pc_src_e, result_src_w;
  logic [4:0] rd_w;

  pipe_hazard_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
    .jump_d(jump_d), .beq_d(beq_d), .bne_d(bne_d), .jalr_d(jalr_d),
    .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .pc_src_e(pc_src_e),
    .mem_write_m(mem_write_m), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .rd_w(rd_w), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       as;
    logic [3:0] br;   // {jump, beq, bne, jalr}
    logic [2:0] alu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       z;
  } dIn_t;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] pc;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
    logic [2:0] alu;
    logic       as;
    logic       mm;
    logic       rw;
    logic [1:0] rsw;
    logic [4:0] rdw;
  } exp_t;

  typedef struct packed {
    dIn_t d;
    exp_t e;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  function automatic dIn_t mkIn(int rw, int rs, int mw, int as, int br, int alu,
                                int rs1, int rs2, int rd, int z);
    dIn_t r;
    r.rw = rw[0];   r.rs = rs[1:0];   r.mw = mw[0];     r.as = as[0];
    r.br = br[3:0]; r.alu = alu[2:0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0];
    r.rd = rd[4:0]; r.z = z[0];
    return r;
  endfunction

  function automatic exp_t mkExp(int fa, int fb, int pc, int st, int fd, int fe, int alu,
                                 int as, int mm, int rw, int rsw, int rdw);
    exp_t r;
    r.fa = fa[1:0]; r.fb = fb[1:0]; r.pc = pc[1:0]; r.sf = st[0]; r.sd = st[0];
    r.fd = fd[0];   r.fe = fe[0];   r.alu = alu[2:0]; r.as = as[0]; r.mm = mm[0];
    r.rw = rw[0];   r.rsw = rsw[1:0]; r.rdw = rdw[4:0];
    return r;
  endfunction

  task automatic add(input dIn_t d, input exp_t e);
    vec_t v;
    v.d = d;
    v.e = e;
    tv.push_back(v);
  endtask

  task automatic apply(input dIn_t d);
    reg_write_d = d.rw; result_src_d = d.rs; mem_write_d = d.mw; alu_src_d = d.as;
    {jump_d, beq_d, bne_d, jalr_d} = d.br;
    alu_control_d = d.alu; rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd; zero_e = d.z;
  endtask

  task automatic chk(input string name, input exp_t e);
    exp_t act;
    act = {forward_a_e, forward_b_e, pc_src_e, stall_f, stall_d, flush_d, flush_e,
           alu_control_e, alu_src_e, mem_write_m, reg_write_w, result_src_w, rd_w};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  initial begin
    dIn_t nop, nopZ;
    exp_t ze;
    nop  = '0;
    nopZ = mkIn(0,0,0,0,0,0,0,0,0,1);
    ze   = '0;

    // forwarding priority: M over W
    add(mkIn(1,0,0,0,0,0,1,2,3,0), ze);
    add(mkIn(1,0,0,0,0,0,1,2,3,0), ze);
    add(mkIn(1,0,0,0,0,2,3,3,4,0), ze);
    add(nop, mkExp(2,2,0,0,0,0,2,0,0,1,0,3));
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,3));
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,4));
    // forwarding from W only
    add(mkIn(1,0,0,0,0,0,1,2,3,0), ze);
    add(nop, ze);
    add(mkIn(1,0,0,0,0,2,3,3,4,0), ze);
    add(nop, mkExp(1,1,0,0,0,0,2,0,0,1,0,3));
    add(nop, ze);
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,4));
    // x0 never forwards
    add(mkIn(1,0,0,0,0,0,0,0,0,0), ze);
    add(mkIn(1,0,0,0,0,0,0,0,0,0), ze);
    add(mkIn(1,0,0,0,0,0,0,0,6,0), ze);
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,0));
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,0));
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,6));
    // load-use: one bubble, then forward from W
    add(mkIn(1,1,0,1,0,0,1,0,2,0), ze);
    add(mkIn(1,0,0,0,0,0,2,1,5,0), mkExp(0,0,0,1,0,1,0,1,0,0,0,0));
    add(mkIn(1,0,0,0,0,0,2,1,5,0), ze);
    add(nop, mkExp(1,0,0,0,0,0,0,0,0,1,1,2));
    add(nop, ze);
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,5));
    // beq taken: flushed add never appears
    add(mkIn(0,0,0,0,4,0,1,2,0,0), ze);
    add(mkIn(1,0,0,0,0,1,0,0,7,1), mkExp(0,0,1,0,1,1,0,0,0,0,0,0));
    add(nopZ, ze);
    // beq not taken: add flows through
    add(mkIn(0,0,0,0,4,0,1,2,0,0), ze);
    add(mkIn(1,0,0,0,0,1,0,0,7,0), ze);
    add(nop, mkExp(0,0,0,0,0,0,1,0,0,0,0,0));
    add(nop, ze);
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,0,7));
    // bne taken on zero=0, not taken on zero=1
    add(mkIn(0,0,0,0,2,0,1,2,0,0), ze);
    add(nop, mkExp(0,0,1,0,1,1,0,0,0,0,0,0));
    add(mkIn(0,0,0,0,2,0,1,2,0,1), ze);
    add(nopZ, ze);
    // jalr: PC from ALU, link still written back
    add(mkIn(1,2,0,1,1,0,5,0,1,0), ze);
    add(nop, mkExp(0,0,2,0,1,1,0,1,0,0,0,0));
    add(nop, ze);
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,2,1));
    // taken and lw_stall together (illegal but defined)
    add(mkIn(1,1,0,0,8,0,0,0,2,0), ze);
    add(mkIn(0,0,0,0,0,0,2,0,0,0), mkExp(0,0,1,1,1,1,0,0,0,0,0,0));
    add(nop, ze);
    add(nop, mkExp(0,0,0,0,0,0,0,0,0,1,1,2));
    // store reaches M two edges later
    add(mkIn(0,0,1,1,0,0,1,2,0,0), ze);
    add(nop, mkExp(0,0,0,0,0,0,0,1,0,0,0,0));
    add(nop, mkExp(0,0,0,0,0,0,0,0,1,0,0,0));
    add(nop, ze);

    rst_n = 1'b1;
    apply(nop);
    #1 rst_n = 1'b0;
    #1 chk("reset_state", ze);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      apply(tv[i].d);
      #1 chk($sformatf("vec%0d", i), tv[i].e);
    end

    // asynchronous reset mid-stream with a stall pending
    @(negedge clk);
    apply(mkIn(1,1,0,1,0,3,1,0,2,0));
    @(negedge clk);
    apply(mkIn(1,0,0,0,1,0,2,0,9,1));
    #1 chk("rst_pre", mkExp(0,0,0,1,0,1,3,1,0,0,0,0));
    #1 rst_n = 1'b0;
    #1 chk("rst_async", ze);
    @(negedge clk);
    #1 chk("rst_hold", ze);
    apply(mkIn(1,0,0,0,0,0,0,0,5,0));
    rst_n = 1'b1;
    #1 chk("rst_release", ze);
    @(negedge clk);
    apply(nop);
    #1 chk("rst_lat1", ze);
    @(negedge clk);
    #1 chk("rst_lat2", ze);
    @(negedge clk);
    #1 chk("rst_lat3", mkExp(0,0,0,0,0,0,0,0,0,1,0,5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
